ila_capture_core: RTL and testbench

//  Capture side of the ILA probe path: receives ila_sample_dut from a DUT, holds a
//  pre/post-trigger window in an on-chip circular buffer, then streams the window
//  out oldest-first over a valid/ready port toward the ILA readout/host link.

---
 rtl/ila_capture_core_pkg.sv | 24 ++
 rtl/ila_capture_ram.sv | 31 +++
 rtl/ila_capture_core.sv | 219 +++++++++++++++++++++
 tb/tb_ila_capture_core.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ila_capture_core_pkg.sv
// rtl/ila_capture_core_pkg.sv - shared state encoding and default sizes for the ILA capture core
package ila_capture_core_pkg;

  localparam int ILA_SAMPLE_W_DEF = 25;
  localparam int ILA_ADDR_W_DEF   = 10;
  localparam int ILA_PRE_TRIG_DEF = 256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRETRIG = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_DONE    = 3'd4
  } ila_state_e;

  function automatic logic is_armed_state(input ila_state_e s);
    return (s == ST_PRETRIG) || (s == ST_ARMED);
  endfunction

  function automatic logic is_triggered_state(input ila_state_e s);
    return (s == ST_POST) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/ila_capture_ram.sv
// rtl/ila_capture_ram.sv - simple dual-port sample buffer, one write port, one registered read port
module ila_capture_ram
  import ila_capture_core_pkg::*;
#(
  parameter int DATA_W = ILA_SAMPLE_W_DEF,
  parameter int ADDR_W = ILA_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage is deliberately left without reset so it maps onto block RAM.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ila_capture_core.sv
// rtl/ila_capture_core.sv - ILA capture: trigger compare, pre/post window FSM, oldest-first readout stream
module ila_capture_core
  import ila_capture_core_pkg::*;
#(
  parameter int SAMPLE_W = ILA_SAMPLE_W_DEF,
  parameter int ADDR_W   = ILA_ADDR_W_DEF,
  parameter int PRE_TRIG = ILA_PRE_TRIG_DEF
) (
  input  logic                clk,
  input  logic                ILA_rst,
  input  logic [SAMPLE_W-1:0] ila_sample_dut,
  input  logic                arm,
  input  logic [SAMPLE_W-1:0] trig_value,
  input  logic [SAMPLE_W-1:0] trig_mask,
  input  logic                trig_force,
  output logic                armed,
  output logic                triggered,
  output logic                done,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_last
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   PRE_LAST  = (ADDR_W+1)'((PRE_TRIG == 0) ? 0 : PRE_TRIG - 1);
  localparam logic [ADDR_W:0]   POST_LAST = (ADDR_W+1)'(DEPTH - PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFF   = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  ila_state_e          state_q, state_d;
  logic [SAMPLE_W-1:0] s_q, s_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rd_base_q, rd_base_d;
  logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
  logic                pend_q, pend_d;
  logic                pend_last_q, pend_last_d;
  logic                out_v_q, out_v_d;
  logic [SAMPLE_W-1:0] out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                sk_v_q, sk_v_d;
  logic [SAMPLE_W-1:0] sk_data_q, sk_data_d;
  logic                sk_last_q, sk_last_d;
  logic                armed_q, armed_d;
  logic                triggered_q, triggered_d;
  logic                done_q, done_d;

  logic                match;
  logic                we;
  logic                issue;
  logic                accept;
  logic [1:0]          occ;
  logic [ADDR_W-1:0]   rd_addr;
  logic [SAMPLE_W-1:0] ram_rdata;

  assign match   = ((s_q ^ trig_value) & trig_mask) == '0;
  assign accept  = out_v_q & rd_ready;
  assign rd_addr = rd_base_q + rd_cnt_q[ADDR_W-1:0];
  // Beats held or in flight after this cycle's handoff; never exceeds the two output slots.
  assign occ     = 2'(out_v_q) + 2'(sk_v_q) + 2'(pend_q) - 2'(accept);

  always_comb begin
    state_d     = state_q;
    s_d         = ila_sample_dut;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    rd_base_d   = rd_base_q;
    rd_cnt_d    = rd_cnt_q;
    pend_d      = 1'b0;
    pend_last_d = pend_last_q;
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    sk_v_d      = sk_v_q;
    sk_data_d   = sk_data_q;
    sk_last_d   = sk_last_q;
    we          = 1'b0;
    issue       = 1'b0;

    case (state_q)
      ST_PRETRIG: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == PRE_LAST) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (match || trig_force) begin
          rd_base_d = wr_ptr_q - PRE_OFF;
          cnt_d     = CNT_ONE;
          rd_cnt_d  = '0;
          state_d   = (POST_LAST == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == POST_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        issue       = (rd_cnt_q != CNT_DEPTH) && (occ < 2'd2);
        pend_d      = issue;
        pend_last_d = (rd_cnt_q == CNT_LAST);
        rd_cnt_d    = rd_cnt_q + (ADDR_W+1)'(issue);
        // Output slot refills from the skid first so beat order is preserved.
        if (accept || !out_v_q) begin
          if (sk_v_q) begin
            out_v_d    = 1'b1;
            out_data_d = sk_data_q;
            out_last_d = sk_last_q;
            sk_v_d     = pend_q;
            sk_data_d  = ram_rdata;
            sk_last_d  = pend_last_q;
          end else begin
            out_v_d    = pend_q;
            if (pend_q) out_data_d = ram_rdata;
            out_last_d = pend_q & pend_last_q;
          end
        end else if (pend_q) begin
          sk_v_d    = 1'b1;
          sk_data_d = ram_rdata;
          sk_last_d = pend_last_q;
        end
        if (accept && out_last_q) begin
          state_d    = ST_IDLE;
          out_v_d    = 1'b0;
          out_last_d = 1'b0;
          sk_v_d     = 1'b0;
          pend_d     = 1'b0;
        end
      end
      default: ;
    endcase

    // A new arm always wins: abandon capture or readout and start from a clean buffer.
    if (arm) begin
      we         = 1'b0;
      wr_ptr_d   = '0;
      cnt_d      = '0;
      rd_cnt_d   = '0;
      pend_d     = 1'b0;
      out_v_d    = 1'b0;
      out_last_d = 1'b0;
      sk_v_d     = 1'b0;
      state_d    = (PRE_TRIG == 0) ? ST_ARMED : ST_PRETRIG;
    end

    armed_d     = is_armed_state(state_d);
    triggered_d = is_triggered_state(state_d);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge ILA_rst) begin
    if (ILA_rst) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_base_q   <= '0;
      rd_cnt_q    <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sk_v_q      <= 1'b0;
      sk_data_q   <= '0;
      sk_last_q   <= 1'b0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      rd_base_q   <= rd_base_d;
      rd_cnt_q    <= rd_cnt_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      sk_v_q      <= sk_v_d;
      sk_data_q   <= sk_data_d;
      sk_last_q   <= sk_last_d;
      armed_q     <= armed_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  ila_capture_ram #(
    .DATA_W(SAMPLE_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr_q),
    .wdata(s_q),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

  assign armed     = armed_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign rd_valid  = out_v_q;
  assign rd_data   = out_data_q;
  assign rd_last   = out_last_q;

endmodule

// File: tb/tb_ila_capture_core.sv
// tb/tb_ila_capture_core.sv - directed/randomized bench for ila_capture_core with a counter probe
module tb_ila_capture_core;

  localparam int SAMPLE_W = 25;
  localparam int ADDR_W   = 4;
  localparam int PRE_TRIG = 4;
  localparam int DEPTH    = 16;

  logic                clk = 1'b0;
  logic                ILA_rst;
  logic [SAMPLE_W-1:0] ila_sample_dut;
  logic                arm;
  logic [SAMPLE_W-1:0] trig_value;
  logic [SAMPLE_W-1:0] trig_mask;
  logic                trig_force;
  logic                armed;
  logic                triggered;
  logic                done;
  logic                rd_valid;
  logic                rd_ready;
  logic [SAMPLE_W-1:0] rd_data;
  logic                rd_last;

  int checks   = 0;
  int failures = 0;
  logic [SAMPLE_W-1:0] ctr;

  ila_capture_core #(
    .SAMPLE_W(SAMPLE_W),
    .ADDR_W  (ADDR_W),
    .PRE_TRIG(PRE_TRIG)
  ) dut (
    .clk           (clk),
    .ILA_rst       (ILA_rst),
    .ila_sample_dut(ila_sample_dut),
    .arm           (arm),
    .trig_value    (trig_value),
    .trig_mask     (trig_mask),
    .trig_force    (trig_force),
    .armed         (armed),
    .triggered     (triggered),
    .done          (done),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_last       (rd_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // The probe is a free-running counter that restarts from 0 when reset is released.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!ILA_rst) ctr = ctr + SAMPLE_W'(1);
    ila_sample_dut = ctr;
  endtask

  task automatic do_reset();
    ILA_rst    = 1'b1;
    arm        = 1'b0;
    trig_force = 1'b0;
    rd_ready   = 1'b0;
    #1;
    chk("rst_armed",     32'(armed),     32'd0);
    chk("rst_triggered", 32'(triggered), 32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_rd_valid",  32'(rd_valid),  32'd0);
    chk("rst_rd_last",   32'(rd_last),   32'd0);
    chk("rst_rd_data",   32'(rd_data),   32'd0);
    tick();
    tick();
    ILA_rst        = 1'b0;
    ctr            = '0;
    ila_sample_dut = '0;
  endtask

  task automatic wait_ctr(input logic [SAMPLE_W-1:0] target);
    int n = 0;
    while (ila_sample_dut != target && n < 3000) begin
      tick();
      n++;
    end
    chk("wait_ctr", 32'(ila_sample_dut), 32'(target));
  endtask

  task automatic arm_pulse(output logic [SAMPLE_W-1:0] c);
    c   = ila_sample_dut;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Reference: the window is nbeats consecutive counter values starting at 'first'.
  task automatic collect(input logic [SAMPLE_W-1:0] first, input int nbeats,
                         input bit rand_ready, input bit full_check);
    int k = 0;
    int cyc = 0;
    int t_done = -1;
    int t_valid = -1;
    bit held = 1'b0;
    logic [SAMPLE_W-1:0] held_data = '0;
    logic held_last = 1'b0;
    logic [SAMPLE_W-1:0] e;
    while (k < nbeats && cyc < 400) begin
      rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) begin
        chk("stall_valid", 32'(rd_valid),  32'd1);
        chk("stall_data",  32'(rd_data),   32'(held_data));
        chk("stall_last",  32'(rd_last),   32'(held_last));
      end
      if (done && t_done < 0) t_done = cyc;
      if (rd_valid && t_valid < 0) t_valid = cyc;
      if (rd_valid && rd_ready) begin
        e = first + SAMPLE_W'(k);
        chk("beat_data", 32'(rd_data), 32'(e));
        chk("beat_last", 32'(rd_last), 32'(k == DEPTH - 1));
        k++;
        held = 1'b0;
      end else begin
        held      = rd_valid;
        held_data = rd_data;
        held_last = rd_last;
      end
      tick();
      cyc++;
    end
    chk("beat_count", 32'(k), 32'(nbeats));
    if (t_done >= 0 && t_valid >= 0)
      chk("first_valid_latency", 32'((t_valid - t_done) <= 2), 32'd1);
    if (full_check) begin
      if (!rand_ready && t_valid >= 0)
        chk("throughput", 32'(cyc - t_valid), 32'(DEPTH));
      chk("end_rd_valid",  32'(rd_valid),  32'd0);
      chk("end_done",      32'(done),      32'd0);
      chk("end_triggered", 32'(triggered), 32'd0);
      chk("end_armed",     32'(armed),     32'd0);
    end
  endtask

  initial begin
    logic [SAMPLE_W-1:0] c;
    logic [SAMPLE_W-1:0] c2;
    int n;
    ILA_rst        = 1'b1;
    ctr            = '0;
    ila_sample_dut = '0;
    arm            = 1'b0;
    trig_value     = '0;
    trig_mask      = '0;
    trig_force     = 1'b0;
    rd_ready       = 1'b0;
    do_reset();

    // Case 1: value trigger at 0x64, free-flowing readout.
    trig_mask  = '1;
    trig_value = 25'h64;
    wait_ctr(25'h10);
    arm_pulse(c);
    chk("c1_armed", 32'(armed), 32'd1);
    chk("c1_not_triggered", 32'(triggered), 32'd0);
    collect(25'h60, DEPTH, 1'b0, 1'b1);

    // Case 2: empty mask triggers on the first ARMED sample.
    trig_mask = '0;
    repeat ($urandom_range(1, 9)) tick();
    arm_pulse(c);
    collect(c, DEPTH, 1'b0, 1'b1);

    // Case 3: value triggers with random backpressure.
    trig_mask = '1;
    for (int i = 0; i < 3; i++) begin
      trig_value = ctr + SAMPLE_W'(10 + $urandom_range(0, 40));
      arm_pulse(c);
      collect(trig_value - SAMPLE_W'(PRE_TRIG), DEPTH, 1'b1, 1'b1);
    end

    // Case 5: reset during POST clears everything, then case 1 reproduces.
    trig_mask = '0;
    arm_pulse(c);
    n = 0;
    while (!triggered && n < 100) begin
      tick();
      n++;
    end
    chk("c5_triggered", 32'(triggered), 32'd1);
    tick();
    tick();
    chk("c5_still_post", 32'(done), 32'd0);
    do_reset();
    trig_mask  = '1;
    trig_value = 25'h64;
    wait_ctr(25'h10);
    arm_pulse(c);
    collect(25'h60, DEPTH, 1'b0, 1'b1);

    // Case 4: match and force during PRETRIG are ignored; force in ARMED at sample 0x20.
    do_reset();
    trig_mask  = '1;
    trig_value = 25'h03;
    wait_ctr(25'h01);
    arm_pulse(c);
    trig_force = 1'b1;
    tick();
    tick();
    trig_force = 1'b0;
    wait_ctr(25'h21);
    chk("c4_no_pretrig_match", 32'(triggered), 32'd0);
    chk("c4_armed", 32'(armed), 32'd1);
    trig_force = 1'b1;
    tick();
    trig_force = 1'b0;
    chk("c4_forced", 32'(triggered), 32'd1);
    collect(25'h1C, DEPTH, 1'b1, 1'b1);

    // Case 6a: re-arm while ARMED abandons the pending capture.
    trig_value = ctr + SAMPLE_W'(200);
    arm_pulse(c);
    repeat (10) tick();
    chk("c6_armed", 32'(armed), 32'd1);
    chk("c6_untriggered", 32'(triggered), 32'd0);
    trig_value = ctr + SAMPLE_W'(8 + $urandom_range(0, 20));
    arm_pulse(c);
    collect(trig_value - SAMPLE_W'(PRE_TRIG), DEPTH, 1'b1, 1'b1);

    // Case 6b: re-arm after 5 readout beats drops rd_valid and restarts.
    trig_mask = '0;
    arm_pulse(c);
    collect(c, 5, 1'b1, 1'b0);
    rd_ready = 1'b0;
    arm_pulse(c2);
    chk("c6_abort_rd_valid", 32'(rd_valid), 32'd0);
    chk("c6_abort_done", 32'(done), 32'd0);
    chk("c6_abort_armed", 32'(armed), 32'd1);
    collect(c2, DEPTH, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
